// File: rtl/cpu_cu_pkg.sv
// Shared types for the CPU control unit: FSM state encodings, opcodes,
// instruction classes and the branch-condition select.
package cpu_cu_pkg;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_IDLE    = 4'd1,
        S_FETCH   = 4'd2,
        S_DECODE  = 4'd3,
        S_ALU     = 4'd4,
        S_LD      = 4'd5,
        S_ST      = 4'd6,
        S_LDI     = 4'd7,
        S_JMP     = 4'd8,
        S_BR      = 4'd9,
        S_HALT    = 4'd10,
        S_ILLEGAL = 4'd11
    } cu_state_e;

    localparam logic [6:0] OP_LD   = 7'h40;
    localparam logic [6:0] OP_ST   = 7'h41;
    localparam logic [6:0] OP_LDI  = 7'h42;
    localparam logic [6:0] OP_JMP  = 7'h43;
    localparam logic [6:0] OP_BZ   = 7'h44;
    localparam logic [6:0] OP_BNZ  = 7'h45;
    localparam logic [6:0] OP_BC   = 7'h46;
    localparam logic [6:0] OP_BN   = 7'h47;
    localparam logic [6:0] OP_HALT = 7'h7F;

    typedef enum logic [2:0] {
        IC_ALU  = 3'd0,
        IC_LD   = 3'd1,
        IC_ST   = 3'd2,
        IC_LDI  = 3'd3,
        IC_JMP  = 3'd4,
        IC_BR   = 3'd5,
        IC_HALT = 3'd6,
        IC_BAD  = 3'd7
    } instr_class_e;

    // Branch select equals the low two opcode bits of BZ/BNZ/BC/BN.
    typedef enum logic [1:0] {
        BR_Z  = 2'd0,
        BR_NZ = 2'd1,
        BR_C  = 2'd2,
        BR_N  = 2'd3
    } br_sel_e;

    function automatic cu_state_e exec_state(instr_class_e ic, logic illegal_halts);
        cu_state_e st;
        case (ic)
            IC_ALU:  st = S_ALU;
            IC_LD:   st = S_LD;
            IC_ST:   st = S_ST;
            IC_LDI:  st = S_LDI;
            IC_JMP:  st = S_JMP;
            IC_BR:   st = S_BR;
            IC_HALT: st = S_HALT;
            IC_BAD:  st = illegal_halts ? S_ILLEGAL : S_IDLE;
            default: st = S_RESET;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/cu_checker.sv
// Protocol assertions for the control-unit strobes: PC update sources and
// register/memory writes are mutually exclusive.
module cu_checker (
    input logic clk,
    input logic reset,
    input logic pc_ld,
    input logic pc_inc,
    input logic mem_we,
    input logic reg_w_en
);

    a_pc_excl: assert property (@(posedge clk) disable iff (reset) !(pc_ld && pc_inc));
    a_wr_excl: assert property (@(posedge clk) disable iff (reset) !(mem_we && reg_w_en));

endmodule

// File: rtl/cu_decode.sv
// Combinational opcode decode: classifies the registered IR opcode and
// extracts the branch-condition select.
module cu_decode
    import cpu_cu_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] iclass_o,
    output logic [1:0] br_sel_o
);

    // Opcode classification; anything not listed is undefined.
    always_comb begin
        iclass_o = IC_BAD;
        br_sel_o = opcode_i[1:0];
        if (opcode_i[6] == 1'b0) begin
            iclass_o = IC_ALU;
        end else begin
            case (opcode_i)
                OP_LD:   iclass_o = IC_LD;
                OP_ST:   iclass_o = IC_ST;
                OP_LDI:  iclass_o = IC_LDI;
                OP_JMP:  iclass_o = IC_JMP;
                OP_BZ, OP_BNZ, OP_BC, OP_BN: iclass_o = IC_BR;
                OP_HALT: iclass_o = IC_HALT;
                default: iclass_o = IC_BAD;
            endcase
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM sequencing the CPU execution unit.
// Optional CU_STATE_DEBUG_EN adds state_dbg and instr_cnt outputs.
module cpu_control_unit
    import cpu_cu_pkg::*;
#(
    parameter logic ILLEGAL_HALTS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic        adr_sel,
    output logic        s_sel,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        reg_w_en,
    output logic        ir_ld,
    output logic        mem_we,
    output logic        halted,
`ifdef CU_STATE_DEBUG_EN
    output logic        illegal,
    output logic [3:0]  state_dbg,
    output logic [15:0] instr_cnt
`else
    output logic        illegal
`endif
);

    cu_state_e    state_q;
    cu_state_e    state_d;
    logic [2:0]   iclass_raw_s;
    logic [1:0]   br_sel_raw_s;
    instr_class_e iclass_s;
    br_sel_e      br_sel_s;
    logic         unused_ir_s;

    assign unused_ir_s = ^ir[8:0];

    cu_decode u_decode (
        .opcode_i (ir[15:9]),
        .iclass_o (iclass_raw_s),
        .br_sel_o (br_sel_raw_s)
    );

    assign iclass_s = instr_class_e'(iclass_raw_s);
    assign br_sel_s = br_sel_e'(br_sel_raw_s);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stray encodings recover through S_RESET.
    always_comb begin
        state_d = S_RESET;
        case (state_q)
            S_RESET:   state_d = S_IDLE;
            S_IDLE:    state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = exec_state(iclass_s, ILLEGAL_HALTS);
            S_ALU, S_LD, S_ST, S_LDI, S_JMP, S_BR: state_d = S_IDLE;
            S_HALT:    state_d = S_HALT;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_RESET;
        endcase
    end

    // Strobe decode from the current state; branch load is Mealy on the flags.
    always_comb begin
        adr_sel  = 1'b0;
        s_sel    = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        reg_w_en = 1'b0;
        ir_ld    = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            S_ALU: begin
                reg_w_en = 1'b1;
            end
            S_LD: begin
                adr_sel  = 1'b1;
                s_sel    = 1'b1;
                reg_w_en = 1'b1;
            end
            S_ST: begin
                adr_sel = 1'b1;
                mem_we  = 1'b1;
            end
            S_LDI: begin
                s_sel    = 1'b1;
                reg_w_en = 1'b1;
                pc_inc   = 1'b1;
            end
            S_JMP: begin
                pc_ld = 1'b1;
            end
            S_BR: begin
                case (br_sel_s)
                    BR_Z:    pc_ld = Z;
                    BR_NZ:   pc_ld = ~Z;
                    BR_C:    pc_ld = C;
                    BR_N:    pc_ld = N;
                    default: pc_ld = 1'b0;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ILLEGAL: begin
                halted  = 1'b1;
                illegal = 1'b1;
            end
            default: begin
                adr_sel = 1'b0;
            end
        endcase
    end

`ifdef CU_STATE_DEBUG_EN
    logic [15:0] instr_cnt_q;
    logic [15:0] instr_cnt_d;
    logic        in_exec_s;

    // Every execute state lasts exactly one cycle, so each cycle spent there retires one instruction.
    always_comb begin
        in_exec_s = 1'b0;
        case (state_q)
            S_ALU, S_LD, S_ST, S_LDI, S_JMP, S_BR: in_exec_s = 1'b1;
            default: in_exec_s = 1'b0;
        endcase
        if (in_exec_s && (instr_cnt_q != 16'hFFFF)) begin
            instr_cnt_d = instr_cnt_q + 16'd1;
        end else begin
            instr_cnt_d = instr_cnt_q;
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt_q <= 16'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign state_dbg = state_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench: a tiny PC/IR/RAM model driven by DUT1 strobes; DUT1 has
// ILLEGAL_HALTS=1, DUT2 (ILLEGAL_HALTS=0) shares its IR, flags and reset.
module tb_cpu_control_unit;

    localparam logic [8:0] V_ZERO  = 9'b000000000;
    localparam logic [8:0] V_FETCH = 9'b000101000;
    localparam logic [8:0] V_ALU   = 9'b000010000;
    localparam logic [8:0] V_LD    = 9'b110010000;
    localparam logic [8:0] V_ST    = 9'b100000100;
    localparam logic [8:0] V_LDI   = 9'b010110000;
    localparam logic [8:0] V_PCLD  = 9'b001000000;
    localparam logic [8:0] V_HALT  = 9'b000000010;
    localparam logic [8:0] V_ILL   = 9'b000000011;

    typedef struct {
        string      name;
        logic [8:0] c1;
        logic [8:0] c2;
        bit         chk_pc;
        logic [7:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        C, N, Z;
    logic [15:0] ir_q;
    logic [7:0]  pc_q;
    logic [7:0]  alu_tgt;
    logic [15:0] ram [0:255];

    logic adr_sel1, s_sel1, pc_ld1, pc_inc1, reg_w_en1, ir_ld1, mem_we1, halted1, illegal1;
    logic adr_sel2, s_sel2, pc_ld2, pc_inc2, reg_w_en2, ir_ld2, mem_we2, halted2, illegal2;
    logic [8:0] vec1, vec2;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef CU_STATE_DEBUG_EN
    logic [3:0]  state_dbg1, state_dbg2;
    logic [15:0] instr_cnt1, instr_cnt2;
`endif

    always #5 clk = ~clk;

    cpu_control_unit #(.ILLEGAL_HALTS(1'b1)) dut1 (
        .clk(clk), .reset(reset), .run(run), .ir(ir_q), .C(C), .N(N), .Z(Z),
        .adr_sel(adr_sel1), .s_sel(s_sel1), .pc_ld(pc_ld1), .pc_inc(pc_inc1),
        .reg_w_en(reg_w_en1), .ir_ld(ir_ld1), .mem_we(mem_we1), .halted(halted1),
`ifdef CU_STATE_DEBUG_EN
        .illegal(illegal1), .state_dbg(state_dbg1), .instr_cnt(instr_cnt1)
`else
        .illegal(illegal1)
`endif
    );

    cpu_control_unit #(.ILLEGAL_HALTS(1'b0)) dut2 (
        .clk(clk), .reset(reset), .run(run), .ir(ir_q), .C(C), .N(N), .Z(Z),
        .adr_sel(adr_sel2), .s_sel(s_sel2), .pc_ld(pc_ld2), .pc_inc(pc_inc2),
        .reg_w_en(reg_w_en2), .ir_ld(ir_ld2), .mem_we(mem_we2), .halted(halted2),
`ifdef CU_STATE_DEBUG_EN
        .illegal(illegal2), .state_dbg(state_dbg2), .instr_cnt(instr_cnt2)
`else
        .illegal(illegal2)
`endif
    );

    cu_checker chk1 (.clk(clk), .reset(reset), .pc_ld(pc_ld1), .pc_inc(pc_inc1),
                     .mem_we(mem_we1), .reg_w_en(reg_w_en1));
    cu_checker chk2 (.clk(clk), .reset(reset), .pc_ld(pc_ld2), .pc_inc(pc_inc2),
                     .mem_we(mem_we2), .reg_w_en(reg_w_en2));

    assign vec1 = {adr_sel1, s_sel1, pc_ld1, pc_inc1, reg_w_en1, ir_ld1, mem_we1, halted1, illegal1};
    assign vec2 = {adr_sel2, s_sel2, pc_ld2, pc_inc2, reg_w_en2, ir_ld2, mem_we2, halted2, illegal2};

    // Minimal execution-unit model: PC and IR follow DUT1's strobes.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= 8'd0;
            ir_q <= 16'h0000;
        end else begin
            if (ir_ld1) ir_q <= ram[pc_q];
            if (pc_inc1) pc_q <= pc_q + 8'd1;
            else if (pc_ld1) pc_q <= alu_tgt;
        end
    end

    // Monitor: one expected strobe vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (vec1 !== e.c1) begin
                errors++;
                $display("FAIL %s dut1 strobes got %b expected %b", e.name, vec1, e.c1);
            end
            checks++;
            if (vec2 !== e.c2) begin
                errors++;
                $display("FAIL %s dut2 strobes got %b expected %b", e.name, vec2, e.c2);
            end
            if (e.chk_pc) begin
                checks++;
                if (pc_q !== e.pc) begin
                    errors++;
                    $display("FAIL %s pc got %0d expected %0d", e.name, pc_q, e.pc);
                end
            end
        end
    end

    task automatic push(input string n, input logic [8:0] a, input logic [8:0] b,
                        input bit cp, input logic [7:0] p);
        exp_t e;
        e.name = n; e.c1 = a; e.c2 = b; e.chk_pc = cp; e.pc = p;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called one step into S_FETCH; leaves the bench one step into the next S_FETCH.
    task automatic instr(input string n, input logic [8:0] ex, input logic z, input logic c,
                         input logic nf, input logic [7:0] tgt, input logic [7:0] pc_after);
        Z = z; C = c; N = nf; alu_tgt = tgt;
        push({n, "/fetch"},  V_FETCH, V_FETCH, 1'b0, 8'd0);
        push({n, "/decode"}, V_ZERO,  V_ZERO,  1'b0, 8'd0);
        push({n, "/exec"},   ex,      ex,      1'b0, 8'd0);
        push({n, "/idle"},   V_ZERO,  V_ZERO,  1'b1, pc_after);
        step(4);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; C = 1'b0; N = 1'b0; Z = 1'b0; alu_tgt = 8'd0;
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[0]  = 16'h0123;
        ram[1]  = 16'h8600;
        ram[5]  = 16'h8400;
        ram[6]  = 16'h1234;
        ram[7]  = 16'h8800;
        ram[10] = 16'h8800;
        ram[11] = 16'h8200;
        ram[12] = 16'h8000;
        ram[13] = 16'h8A00;
        ram[20] = 16'h8C00;
        ram[30] = 16'h8E00;
        ram[31] = 16'h8E00;
        ram[33] = 16'hA000;

        @(posedge clk); #1;
        push("reset", V_ZERO, V_ZERO, 1'b1, 8'd0);
        step(1);
        reset = 1'b0; run = 1'b1;
        push("post_reset", V_ZERO, V_ZERO, 1'b0, 8'd0);
        push("first_idle", V_ZERO, V_ZERO, 1'b0, 8'd0);
        step(2);

        instr("alu",       V_ALU,  1'b0, 1'b0, 1'b0, 8'd0,  8'd1);
        instr("jmp",       V_PCLD, 1'b0, 1'b0, 1'b0, 8'd5,  8'd5);
        instr("ldi",       V_LDI,  1'b0, 1'b0, 1'b0, 8'd0,  8'd7);
        instr("bz_taken",  V_PCLD, 1'b1, 1'b0, 1'b0, 8'd10, 8'd10);
        instr("bz_not",    V_ZERO, 1'b0, 1'b1, 1'b1, 8'd40, 8'd11);
        instr("st",        V_ST,   1'b0, 1'b0, 1'b0, 8'd0,  8'd12);
        instr("ld",        V_LD,   1'b0, 1'b0, 1'b0, 8'd0,  8'd13);
        instr("bnz_taken", V_PCLD, 1'b0, 1'b0, 1'b0, 8'd20, 8'd20);
        instr("bc_taken",  V_PCLD, 1'b0, 1'b1, 1'b0, 8'd30, 8'd30);
        instr("bn_not",    V_ZERO, 1'b1, 1'b1, 1'b0, 8'd50, 8'd31);
        instr("bn_taken",  V_PCLD, 1'b0, 1'b0, 1'b1, 8'd33, 8'd33);

        // Undefined opcode: DUT1 sticks in S_ILLEGAL, DUT2 keeps fetching.
        push("ill/fetch",  V_FETCH, V_FETCH, 1'b0, 8'd0);
        push("ill/decode", V_ZERO,  V_ZERO,  1'b0, 8'd0);
        push("ill/c3",     V_ILL,   V_ZERO,  1'b0, 8'd0);
        push("ill/c4",     V_ILL,   V_FETCH, 1'b0, 8'd0);
        push("ill/c5",     V_ILL,   V_ZERO,  1'b0, 8'd0);
        push("ill/c6",     V_ILL,   V_ZERO,  1'b0, 8'd0);
        push("ill/c7",     V_ILL,   V_FETCH, 1'b1, 8'd34);
        step(7);

        reset = 1'b1;
        push("ill_reset", V_ZERO, V_ZERO, 1'b1, 8'd0);
        step(1);
        ram[0] = 16'h8000;
        ram[1] = 16'hFE00;
        reset = 1'b0; run = 1'b1;
        push("rel2", V_ZERO, V_ZERO, 1'b0, 8'd0);
        push("idle2", V_ZERO, V_ZERO, 1'b0, 8'd0);
        step(2);
        push("ld_abort/fetch",  V_FETCH, V_FETCH, 1'b0, 8'd0);
        push("ld_abort/decode", V_ZERO,  V_ZERO,  1'b0, 8'd0);
        step(2);
        reset = 1'b1;
        push("reset_in_ld", V_ZERO, V_ZERO, 1'b1, 8'd0);
        step(1);
        reset = 1'b0; run = 1'b0;
        push("rel3", V_ZERO, V_ZERO, 1'b0, 8'd0);
        push("hold_idle_a", V_ZERO, V_ZERO, 1'b0, 8'd0);
        step(2);

        // run pulsed for one cycle: the instruction still completes, then IDLE holds.
        run = 1'b1;
        push("hold_idle_b", V_ZERO, V_ZERO, 1'b0, 8'd0);
        step(1);
        run = 1'b0;
        push("ld2/fetch",  V_FETCH, V_FETCH, 1'b0, 8'd0);
        push("ld2/decode", V_ZERO,  V_ZERO,  1'b0, 8'd0);
        push("ld2/exec",   V_LD,    V_LD,    1'b0, 8'd0);
        push("ld2/idle1",  V_ZERO,  V_ZERO,  1'b0, 8'd0);
        push("ld2/idle2",  V_ZERO,  V_ZERO,  1'b0, 8'd0);
        push("ld2/idle3",  V_ZERO,  V_ZERO,  1'b1, 8'd1);
        step(6);

        run = 1'b1;
        push("pre_halt_idle", V_ZERO, V_ZERO, 1'b0, 8'd0);
        step(1);
        push("halt/fetch",  V_FETCH, V_FETCH, 1'b0, 8'd0);
        push("halt/decode", V_ZERO,  V_ZERO,  1'b0, 8'd0);
        push("halt/c3",     V_HALT,  V_HALT,  1'b0, 8'd0);
        push("halt/c4",     V_HALT,  V_HALT,  1'b0, 8'd0);
        push("halt/c5",     V_HALT,  V_HALT,  1'b1, 8'd2);
        step(5);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain queue left %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
